// File: rtl/fpu_config_sequencer.sv
// Loads filter taps, image dims and base addresses over a req/valid read port.
// Shadow values commit atomically; CFG_CHECK_EN adds a sanity check before commit.
module fpu_config_sequencer #(
    parameter int                FILTER_TAPS = 9,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] DIMS_ADDR   = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] START_ADDR  = 32'h1000_0020,
    parameter logic [ADDR_W-1:0] FILTER_ADDR = 32'h1000_0040,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = 32'h1000_0100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [31:0]              mem_data,
    input  logic                     mem_valid,
    output logic [8*FILTER_TAPS-1:0] filter,
    output logic [15:0]              image_width,
    output logic [15:0]              image_height,
    output logic [31:0]              start_address,
    output logic [31:0]              result_address,
    output logic                     busy,
    output logic                     load_done,
    output logic                     cfg_err
);

    localparam int FILTER_WORDS = (FILTER_TAPS + 3) / 4;
    localparam int WC_W = (FILTER_WORDS > 1) ? $clog2(FILTER_WORDS) : 1;
    localparam logic [WC_W-1:0] LAST_W = WC_W'(FILTER_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILTER,
        S_DIMS,
        S_START,
        S_RESULT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WC_W-1:0]          w;
    logic [8*FILTER_TAPS-1:0] sh_filter;
    logic [31:0]              sh_dims;
    logic [31:0]              sh_start;
    logic [31:0]              sh_result;
    logic                     accept;
    logic                     hs;

    assign accept = (state == S_IDLE) && load_start;
    assign hs     = mem_req && mem_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        busy      = 1'b1;
        load_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (load_start) state_nxt = S_FILTER;
            end
            S_FILTER: begin
                mem_req  = 1'b1;
                mem_addr = FILTER_ADDR + ADDR_W'({w, 2'b00});
                if (mem_valid && (w == LAST_W)) state_nxt = S_DIMS;
            end
            S_DIMS: begin
                mem_req  = 1'b1;
                mem_addr = DIMS_ADDR;
                if (mem_valid) state_nxt = S_START;
            end
            S_START: begin
                mem_req  = 1'b1;
                mem_addr = START_ADDR;
                if (mem_valid) state_nxt = S_RESULT;
            end
            S_RESULT: begin
                mem_req  = 1'b1;
                mem_addr = RESULT_ADDR;
                if (mem_valid) state_nxt = S_DONE;
            end
            S_DONE: begin
                load_done = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef CFG_CHECK_EN
    // Result word is still on mem_data at the commit edge, so check it there.
    logic cfg_bad;
    assign cfg_bad = (sh_dims[31:16] == 16'd0) || (sh_dims[15:0] == 16'd0) ||
                     (sh_start[1:0] != 2'd0) || (mem_data[1:0] != 2'd0);
`else
    assign cfg_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w              <= '0;
            sh_filter      <= '0;
            sh_dims        <= '0;
            sh_start       <= '0;
            sh_result      <= '0;
            filter         <= '0;
            image_width    <= '0;
            image_height   <= '0;
            start_address  <= '0;
            result_address <= '0;
`ifdef CFG_CHECK_EN
            cfg_err        <= 1'b0;
`endif
        end else begin
            if (accept) begin
                w <= '0;
`ifdef CFG_CHECK_EN
                cfg_err <= 1'b0;
`endif
            end
            if (hs) begin
                unique case (state)
                    S_FILTER: begin
                        for (int i = 0; i < FILTER_TAPS; i++) begin
                            if (i / 4 == int'(w))
                                sh_filter[8*i +: 8] <= mem_data[31-8*(i%4) -: 8];
                        end
                        w <= (w == LAST_W) ? '0 : w + WC_W'(1);
                    end
                    S_DIMS:  sh_dims  <= mem_data;
                    S_START: sh_start <= mem_data;
                    S_RESULT: begin
                        sh_result <= mem_data;
`ifdef CFG_CHECK_EN
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            cfg_err        <= 1'b0;
                            filter         <= sh_filter;
                            image_width    <= sh_dims[31:16];
                            image_height   <= sh_dims[15:0];
                            start_address  <= sh_start;
                            result_address <= mem_data;
                        end
`else
                        filter         <= sh_filter;
                        image_width    <= sh_dims[31:16];
                        image_height   <= sh_dims[15:0];
                        start_address  <= sh_start;
                        result_address <= mem_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_config_sequencer.sv
// Bench for fpu_config_sequencer: a 9-tap and a 25-tap instance driven by a
// bench-side memory with random wait states, checked against a config model.
module tb_fpu_config_sequencer;

    localparam logic [31:0] DA = 32'h1000_0000;
    localparam logic [31:0] SA = 32'h1000_0020;
    localparam logic [31:0] FA = 32'h1000_0040;
    localparam logic [31:0] RA = 32'h1000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        sel;

    logic         req1, busy1, done1, err1;
    logic [31:0]  addr1, sa1, ra1;
    logic [71:0]  f1;
    logic [15:0]  w1, h1;
    logic         req2, busy2, done2, err2;
    logic [31:0]  addr2, sa2, ra2;
    logic [199:0] f2;
    logic [15:0]  w2, h2;

    logic         v_req, v_busy, v_done, v_err;
    logic [31:0]  v_addr, v_start, v_result;
    logic [511:0] v_filter;
    logic [15:0]  v_w, v_h;

    logic [31:0]  fw [16];
    logic [31:0]  c_dims, c_start, c_result;
    logic [511:0] e_filter;
    logic [15:0]  e_w, e_h;
    logic [31:0]  e_s, e_r;

    int n_cmp = 0;
    int n_fail = 0;
    int lat;

    always #5 clk = ~clk;

    fpu_config_sequencer #(.FILTER_TAPS(9)) dut1 (
        .clk(clk), .rst(rst), .load_start(load_start & ~sel),
        .mem_req(req1), .mem_addr(addr1), .mem_data(mem_data),
        .mem_valid(mem_valid & ~sel), .filter(f1),
        .image_width(w1), .image_height(h1),
        .start_address(sa1), .result_address(ra1),
        .busy(busy1), .load_done(done1), .cfg_err(err1)
    );

    fpu_config_sequencer #(.FILTER_TAPS(25)) dut2 (
        .clk(clk), .rst(rst), .load_start(load_start & sel),
        .mem_req(req2), .mem_addr(addr2), .mem_data(mem_data),
        .mem_valid(mem_valid & sel), .filter(f2),
        .image_width(w2), .image_height(h2),
        .start_address(sa2), .result_address(ra2),
        .busy(busy2), .load_done(done2), .cfg_err(err2)
    );

    assign v_req    = sel ? req2 : req1;
    assign v_addr   = sel ? addr2 : addr1;
    assign v_filter = sel ? 512'(f2) : 512'(f1);
    assign v_w      = sel ? w2 : w1;
    assign v_h      = sel ? h2 : h1;
    assign v_start  = sel ? sa2 : sa1;
    assign v_result = sel ? ra2 : ra1;
    assign v_busy   = sel ? busy2 : busy1;
    assign v_done   = sel ? done2 : done1;
    assign v_err    = sel ? err2 : err1;

    task automatic chkw(input string tag, input logic [607:0] obs, input logic [607:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [607:0] obs_pack();
        return {v_filter, v_w, v_h, v_start, v_result};
    endfunction

    function automatic logic [607:0] exp_pack();
        return {e_filter, e_w, e_h, e_s, e_r};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - FA;
        if (a == DA) return c_dims;
        if (a == SA) return c_start;
        if (a == RA) return c_result;
        if (a >= FA && a < FA + 32'd64) return fw[off[5:2]];
        return 32'hDEAD_BEEF;
    endfunction

    // Tap t is byte (t mod 4) of word t/4, most significant byte first.
    function automatic logic [511:0] model_filter(input int nt);
        logic [511:0] f;
        logic [31:0]  wd;
        f = '0;
        for (int t = 0; t < nt; t++) begin
            wd = fw[t / 4];
            f[8*t +: 8] = 8'(wd >> (8 * (3 - t % 4)));
        end
        return f;
    endfunction

    function automatic logic model_err();
`ifdef CFG_CHECK_EN
        return (c_dims[31:16] == 0) || (c_dims[15:0] == 0) ||
               (c_start[1:0] != 0) || (c_result[1:0] != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic zero_exp();
        e_filter = '0;
        e_w = '0;
        e_h = '0;
        e_s = '0;
        e_r = '0;
    endtask

    task automatic new_cfg(input bit bad);
        logic [31:0] r;
        for (int k = 0; k < 16; k++) fw[k] = $urandom;
        c_dims = {16'($urandom_range(4096, 1)), 16'($urandom_range(4096, 1))};
        r = $urandom;
        c_start = r & ~32'h3;
        r = $urandom;
        c_result = r & ~32'h3;
        if (bad) c_start = c_start | 32'h2;
    endtask

    task automatic do_load(input int max_wait, input bit fixed,
                           input int abort_after, output int lat_o);
        int nt, nw, rd, wl, cyc, tw;
        bit inrd, fin, timeout, aborted;
        logic [31:0] cur;
        logic [31:0] ea [$];
        logic err;
        nt = sel ? 25 : 9;
        nw = (nt + 3) / 4;
        ea = {};
        for (int k = 0; k < nw; k++) ea.push_back(FA + 32'(4 * k));
        ea.push_back(DA);
        ea.push_back(SA);
        ea.push_back(RA);
        rd = 0; cyc = 0; wl = 0; tw = 0; cur = '0;
        inrd = 0; timeout = 0; aborted = 0;
        @(negedge clk);
        load_start = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            load_start = (cyc == 2);
            if (v_done) break;
            if (cyc > 600) begin
                timeout = 1;
                break;
            end
            chkw("hold", obs_pack(), exp_pack());
            chkb("busy", v_busy, 1'b1);
            chkb("req", v_req, 1'b1);
            if (!inrd) begin
                inrd = 1;
                cur = v_addr;
                chki("addr", v_addr, (rd < ea.size()) ? ea[rd] : 32'hFFFF_FFFF);
                wl = fixed ? max_wait : int'($urandom_range(max_wait, 0));
                tw += wl;
            end else begin
                chki("addr_stable", v_addr, cur);
            end
            fin = (wl == 0);
            if (fin) begin
                mem_valid = 1'b1;
                mem_data = mem_word(cur);
            end else begin
                mem_valid = 1'b0;
                mem_data = $urandom;
                wl--;
            end
            @(posedge clk);
            cyc++;
            if (fin) begin
                inrd = 0;
                rd++;
                if (rd == abort_after) begin
                    aborted = 1;
                    break;
                end
            end
        end
        load_start = 1'b0;
        lat_o = cyc;
        if (timeout) begin
            chki("timeout", cyc, 0);
        end else if (aborted) begin
            @(negedge clk);
            mem_valid = 1'b0;
            rst = 1'b1;
            #1;
            zero_exp();
            chkw("rst_outputs", obs_pack(), exp_pack());
            chkb("rst_busy", v_busy, 1'b0);
            chkb("rst_done", v_done, 1'b0);
            chkb("rst_req", v_req, 1'b0);
            chkb("rst_err", v_err, 1'b0);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            chki("latency", cyc, 32'(ea.size() + tw));
            chki("reads", rd, 32'(ea.size()));
            err = model_err();
            if (!err) begin
                e_filter = model_filter(nt);
                e_w = c_dims[31:16];
                e_h = c_dims[15:0];
                e_s = c_start;
                e_r = c_result;
            end
            chkw("commit", obs_pack(), exp_pack());
            chkb("cfg_err", v_err, err);
            chkb("busy_in_done", v_busy, 1'b1);
            chkb("req_in_done", v_req, 1'b0);
            mem_valid = 1'($urandom_range(1, 0));
            @(negedge clk);
            chkb("idle_busy", v_busy, 1'b0);
            chkb("done_pulse", v_done, 1'b0);
            chkw("hold_idle", obs_pack(), exp_pack());
            mem_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        mem_valid = 1'b0;
        mem_data = '0;
        sel = 1'b0;
        zero_exp();
        repeat (3) @(negedge clk);
        chkw("reset_outputs", obs_pack(), exp_pack());
        chkb("reset_busy", v_busy, 1'b0);
        chkb("reset_done", v_done, 1'b0);
        chkb("reset_req", v_req, 1'b0);
        chkb("reset_err", v_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed load with a zero-wait memory
        for (int k = 0; k < 16; k++) fw[k] = 32'h0;
        fw[0] = 32'h0102_0304;
        fw[1] = 32'h0506_0708;
        fw[2] = 32'h09AB_CDEF;
        c_dims = 32'h0280_01E0;
        c_start = 32'h2000_0000;
        c_result = 32'h3000_0000;
        do_load(0, 1'b1, 0, lat);
        chki("latency_8", lat + 2, 32'd8);
        chkw("taps_1_to_9", 608'(v_filter), 608'(72'h09_0807_0605_0403_0201));
        chki("width_640", 32'(v_w), 32'd640);
        chki("height_480", 32'(v_h), 32'd480);

        // Three wait states per read
        do_load(3, 1'b1, 0, lat);

        // Reloads with random data and random waits
        for (int i = 0; i < 4; i++) begin
            new_cfg(i == 2);
            do_load(3, 1'b0, 0, lat);
        end

        // Zero width, then a good load
        new_cfg(1'b0);
        c_dims = 32'h0000_01E0;
        do_load(1, 1'b0, 0, lat);
        new_cfg(1'b0);
        do_load(1, 1'b0, 0, lat);

        // Reset after the DIMS read, then a fresh load
        new_cfg(1'b0);
        do_load(2, 1'b0, 4, lat);
        new_cfg(1'b0);
        do_load(2, 1'b0, 0, lat);

        // 25-tap instance, untouched since reset
        sel = 1'b1;
        zero_exp();
        @(negedge clk);
        chkw("dut25_idle", obs_pack(), exp_pack());
        for (int i = 0; i < 3; i++) begin
            new_cfg(1'b0);
            do_load(2, 1'b0, 0, lat);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
